// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, with a single sign-fix cycle before results are published.
module muldiv_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned DW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             op_div;
  logic             neg_lo;
  logic             neg_hi;
  logic [WIDTH-1:0] a_orig;
  logic [WIDTH-1:0] opnd;   // multiplicand for multiply, divisor for divide
  logic [DW-1:0]    acc;    // product accumulator, or quotient in the low half
  logic [WIDTH-1:0] rem;

  logic             accept;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [DW-1:0]    mul_next;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_take;
  logic [DW-1:0]    prod_fix;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  // Operand magnitudes, one iteration step of each algorithm, and the sign fix-up
  always_comb begin
    accept    = start && (state == S_IDLE || state == S_DONE);
    a_neg     = ~op[1] & a[WIDTH-1];
    b_neg     = ~op[1] & b[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
    mul_sum   = {1'b0, acc[DW-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_shift = {rem, acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    // The difference never exceeds the divisor, so its top bit is a clean borrow
    div_take  = ~div_diff[WIDTH];
    prod_fix  = neg_lo ? -acc : acc;
    quot_fix  = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix   = neg_hi ? -rem : rem;
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      result_hi   <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      op_div      <= 1'b0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
      a_orig      <= '0;
      opnd        <= '0;
      acc         <= '0;
      rem         <= '0;
    end else if (flush) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_CALC: begin
          cnt <= cnt + CW'(1);
          if (op_div) begin
            rem <= div_take ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            acc <= {acc[DW-1:WIDTH], acc[WIDTH-2:0], div_take};
          end else begin
            acc <= mul_next;
          end
          if (cnt == CW'(WIDTH - 1)) state <= S_FIX;
        end
        S_FIX: begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (!op_div) begin
            {result_hi, result} <= prod_fix;
          end else if (opnd == '0) begin
            result      <= '1;
            result_hi   <= a_orig;
            div_by_zero <= 1'b1;
          end else begin
            result    <= quot_fix;
            result_hi <= rem_fix;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: ;
      endcase
      // A start in IDLE or DONE overrides the DONE -> IDLE return
      if (accept) begin
        state       <= S_CALC;
        busy        <= 1'b1;
        cnt         <= '0;
        op_div      <= op[0];
        neg_lo      <= a_neg ^ b_neg;
        neg_hi      <= a_neg;
        a_orig      <= a;
        rem         <= '0;
        div_by_zero <= 1'b0;
        if (op[0]) begin
          opnd <= b_mag;
          acc  <= {{WIDTH{1'b0}}, a_mag};
        end else begin
          opnd <= a_mag;
          acc  <= {{WIDTH{1'b0}}, b_mag};
        end
      end
    end
  end

endmodule
